// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed seven-segment scanner.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high glyphs, bit order gfedcba.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A_GLYPH = 7'h77;
  localparam logic [6:0] SEG_B_GLYPH = 7'h7C;
  localparam logic [6:0] SEG_C_GLYPH = 7'h39;
  localparam logic [6:0] SEG_D_GLYPH = 7'h5E;
  localparam logic [6:0] SEG_E_GLYPH = 7'h79;
  localparam logic [6:0] SEG_F_GLYPH = 7'h71;

  typedef enum logic {
    ST_ON    = 1'b0,
    ST_GUARD = 1'b1
  } scan_state_t;

  typedef struct packed {
    scan_state_t      state;
    logic [IDX_W-1:0] idx;
  } scan_dbg_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high gfedcba segment pattern.
import seg7_pkg::*;

module seg7_decode (
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_0;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A_GLYPH;
      4'hB: pattern = SEG_B_GLYPH;
      4'hC: pattern = SEG_C_GLYPH;
      4'hD: pattern = SEG_D_GLYPH;
      4'hE: pattern = SEG_E_GLYPH;
      4'hF: pattern = SEG_F_GLYPH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit scanner: ON/GUARD time multiplexing with a double-buffered display
// register that only swaps at frame boundaries.
import seg7_pkg::*;

module seg7_scan #(
  parameter int ON_CYC    = 4000,
  parameter int GUARD_CYC = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [15:0]           in_value,
  input  logic [NUM_DIGITS-1:0] in_dp,
  input  logic [NUM_DIGITS-1:0] in_blank,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_start,
  output scan_dbg_t             dbg
);

  // Handshake: an offer transfers on a rising CLK edge where in_valid and
  // in_ready are both 1; upstream keeps the offer stable until then.

  localparam int MAX_CYC = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);

  scan_state_t      state, nxt_state;
  logic [IDX_W-1:0] idx, nxt_idx;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic             started;

  logic [15:0]           disp_value, pend_value, nxt_value;
  logic [NUM_DIGITS-1:0] disp_dp, pend_dp, nxt_dp;
  logic [NUM_DIGITS-1:0] disp_blank, pend_blank, nxt_blank;
  logic                  pend_full;
  logic                  xfer, enter_frame;

  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [7:0]            nxt_seg_n;
  logic [NUM_DIGITS-1:0] nxt_dig;

  assign in_ready  = ~pend_full;
  assign dbg.state = state;
  assign dbg.idx   = idx;

  // Next phase; the first edge out of reset enters ON(0) without counting.
  always_comb begin
    nxt_state   = state;
    nxt_idx     = idx;
    nxt_cnt     = cnt + 1'b1;
    enter_frame = 1'b0;
    if (!started) begin
      nxt_state   = ST_ON;
      nxt_idx     = '0;
      nxt_cnt     = '0;
      enter_frame = 1'b1;
    end else if (state == ST_ON) begin
      if (cnt == ON_LAST) begin
        nxt_state = ST_GUARD;
        nxt_cnt   = '0;
      end
    end else if (cnt == GUARD_LAST) begin
      nxt_state   = ST_ON;
      nxt_idx     = idx + 1'b1;
      nxt_cnt     = '0;
      enter_frame = (idx == IDX_W'(NUM_DIGITS - 1));
    end
  end

  assign xfer      = enter_frame && started && pend_full;
  assign nxt_value = xfer ? pend_value : disp_value;
  assign nxt_dp    = xfer ? pend_dp    : disp_dp;
  assign nxt_blank = xfer ? pend_blank : disp_blank;
  assign nibble    = nxt_value[{nxt_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // Outputs are precomputed for the phase being entered so they register
  // on the same edge as the state.
  always_comb begin
    nxt_dig   = '0;
    nxt_seg_n = 8'hFF;
    if (nxt_state == ST_ON) begin
      nxt_dig = NUM_DIGITS'(1) << nxt_idx;
      if (!nxt_blank[nxt_idx]) begin
        nxt_seg_n[SEG_DP]      = ~nxt_dp[nxt_idx];
        nxt_seg_n[SEG_G:SEG_A] = ~pattern;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_ON;
      idx         <= '0;
      cnt         <= '0;
      started     <= 1'b0;
      dig         <= '0;
      seg_n       <= 8'hFF;
      frame_start <= 1'b0;
      pend_full   <= 1'b0;
      pend_value  <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
      disp_value  <= '0;
      disp_dp     <= '0;
      disp_blank  <= '1;
    end else begin
      started     <= 1'b1;
      state       <= nxt_state;
      idx         <= nxt_idx;
      cnt         <= nxt_cnt;
      dig         <= nxt_dig;
      seg_n       <= nxt_seg_n;
      frame_start <= enter_frame;
      disp_value  <= nxt_value;
      disp_dp     <= nxt_dp;
      disp_blank  <= nxt_blank;
      if (xfer) begin
        pend_full <= 1'b0;
      end
      if (in_valid && in_ready) begin
        pend_value <= in_value;
        pend_dp    <= in_dp;
        pend_blank <= in_blank;
        pend_full  <= 1'b1;
      end
    end
  end

endmodule
